dsp_opmux_pipe: RTL and testbench

- Parametrised, pipelined 4:1 operand multiplexer for the DSP48A1 slice X/Z operand path.
- Selects one of three full-width operands or one narrow operand, then zero- or sign-extends the narrow operand to the output width.
- Carries data through a clock-enabled pipeline of configurable depth, with a valid flag and a selection-change flag aligned to the data.
- Sits between the operand source registers and the post-adder.

---
 rtl/dsp_opmux_pipe.sv | 124 ++++++++++++
 tb/tb_dsp_opmux_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_opmux_pipe.sv
// dsp_opmux_pipe: pipelined 4:1 operand multiplexer for the DSP X/Z operand path.
// in1 is a narrow operand that is zero- or sign-extended (SEXT) to W_OUT.
// The selected data, its valid flag and a select-change flag travel through
// PIPE clock-enabled register stages.
// Optional feature: define DSP_OPMUX_USAGE_CNT_EN to add sel_cnt, four
// saturating 16-bit per-select usage counters.
module dsp_opmux_pipe #(
  parameter int W_OUT    = 48,
  parameter int W_NARROW = 36,
  parameter int SEXT     = 0,
  parameter int PIPE     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                in_valid,
  input  logic [1:0]          sel,
  input  logic [W_OUT-1:0]    in0,
  input  logic [W_NARROW-1:0] in1,
  input  logic [W_OUT-1:0]    in2,
  input  logic [W_OUT-1:0]    in3,
  output logic [W_OUT-1:0]    out,
  output logic                out_valid,
  output logic                sel_chg
`ifdef DSP_OPMUX_USAGE_CNT_EN
  ,
  output logic [63:0]         sel_cnt
`endif
);

  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $error("dsp_opmux_pipe: PIPE=%0d is outside the legal range 1..4", PIPE);
  end
  if (W_NARROW < 1 || W_NARROW > W_OUT) begin : g_bad_narrow
    $error("dsp_opmux_pipe: W_NARROW=%0d is outside the legal range 1..W_OUT", W_NARROW);
  end

  // Widen in1 to W_OUT: upper bits are a copy of the MSB when SEXT is set,
  // zero otherwise. Writing the fill first then the low field keeps this legal
  // when W_NARROW == W_OUT (the fill is fully overwritten).
  function automatic logic signed [W_OUT-1:0] ext_narrow(input logic [W_NARROW-1:0] v);
    logic signed [W_OUT-1:0] r;
    r = (SEXT != 0 && v[W_NARROW-1]) ? '1 : '0;
    r[W_NARROW-1:0] = v;
    return r;
  endfunction

`ifdef DSP_OPMUX_USAGE_CNT_EN
  // Saturating increment for a 16-bit usage counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic signed [W_OUT-1:0]   mux_p0;
  logic                      vld_p0;
  logic                      chg_p0;

  // Stages are packed side by side; stage 1 occupies the low slice and the
  // output stage (stage PIPE) the high slice.
  logic [PIPE*W_OUT-1:0]     data_q, data_d;
  logic [PIPE-1:0]           vld_q, vld_d;
  logic [PIPE-1:0]           chg_q, chg_d;
  logic [1:0]                last_sel_q;
  logic                      first_q;

  // ---- stage 0: operand select, extension and change detect
  always_comb begin
    case (sel)
      2'd0:    mux_p0 = $signed(in0);
      2'd1:    mux_p0 = ext_narrow(in1);
      2'd2:    mux_p0 = $signed(in2);
      default: mux_p0 = $signed(in3);
    endcase
    vld_p0 = in_valid;
    chg_p0 = in_valid && !first_q && (sel != last_sel_q);
  end

  // Next state of the stage chain: everything moves up one stage.
  always_comb begin
    data_d = (data_q << W_OUT) | (PIPE*W_OUT)'($unsigned(mux_p0));
    vld_d  = (vld_q << 1) | PIPE'(vld_p0);
    chg_d  = (chg_q << 1) | PIPE'(chg_p0);
  end

  // ---- stages 1..PIPE: clock-enabled pipeline plus last accepted select
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q     <= '0;
      vld_q      <= '0;
      chg_q      <= '0;
      last_sel_q <= 2'd0;
      first_q    <= 1'b1;
    end else if (ce) begin
      data_q <= data_d;
      vld_q  <= vld_d;
      chg_q  <= chg_d;
      if (in_valid) begin
        last_sel_q <= sel;
        first_q    <= 1'b0;
      end
    end
  end

  assign out       = data_q[PIPE*W_OUT-1 -: W_OUT];
  assign out_valid = vld_q[PIPE-1];
  assign sel_chg   = chg_q[PIPE-1];

`ifdef DSP_OPMUX_USAGE_CNT_EN
  logic [3:0][15:0] cnt_q;

  // Per-select usage counters, bumped on every accepted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ce && in_valid) begin
      cnt_q[sel] <= sat_inc16(cnt_q[sel]);
    end
  end

  assign sel_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dsp_opmux_pipe.sv
// Testbench for dsp_opmux_pipe: two instances (PIPE=2 zero-extend and
// PIPE=3 sign-extend) share one stimulus stream and are checked every cycle
// against a queue-based reference, plus directed literal expectations.
module tb_dsp_opmux_pipe;
  localparam int PA = 2;
  localparam int PB = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ce, in_valid;
  logic [1:0]  sel;
  logic [47:0] in0, in2, in3;
  logic [35:0] in1;
  logic [47:0] out_a, out_b;
  logic        ov_a, ov_b, ch_a, ch_b;
`ifdef DSP_OPMUX_USAGE_CNT_EN
  logic [63:0] cnt_a, cnt_b;
`endif

  int checks   = 0;
  int failures = 0;

  dsp_opmux_pipe #(.W_OUT(48), .W_NARROW(36), .SEXT(0), .PIPE(PA)) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sel(sel),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out(out_a), .out_valid(ov_a), .sel_chg(ch_a)
`ifdef DSP_OPMUX_USAGE_CNT_EN
    , .sel_cnt(cnt_a)
`endif
  );

  dsp_opmux_pipe #(.W_OUT(48), .W_NARROW(36), .SEXT(1), .PIPE(PB)) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sel(sel),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out(out_b), .out_valid(ov_b), .sel_chg(ch_b)
`ifdef DSP_OPMUX_USAGE_CNT_EN
    , .sel_cnt(cnt_b)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [47:0] d;
    bit          v;
    bit          c;
    bit          known;
  } ent_t;

  ent_t        qa[$];
  ent_t        qb[$];
  logic [1:0]  m_last;
  bit          m_first;
  bit          started = 1'b0;
  int unsigned m_cnt[4];

  function automatic logic [47:0] pick(input bit sx);
    logic signed [47:0] se;
    case (sel)
      2'd0: return in0;
      2'd1: begin
        if (sx) begin
          se = $signed(in1);
          return se;
        end
        return {12'h000, in1};
      end
      2'd2: return in2;
      default: return in3;
    endcase
  endfunction

  always @(posedge clk) begin
    ent_t e;
    bit   chg;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      e.d = 48'h0; e.v = 1'b0; e.c = 1'b0; e.known = 1'b1;
      repeat (PA) qa.push_back(e);
      repeat (PB) qb.push_back(e);
      m_last  = 2'd0;
      m_first = 1'b1;
      m_cnt   = '{0, 0, 0, 0};
      started = 1'b1;
    end else if (ce && started) begin
      chg = in_valid && !m_first && (sel != m_last);
      e.v = in_valid; e.c = chg; e.known = in_valid;
      e.d = pick(1'b0);
      qa.push_back(e); void'(qa.pop_front());
      e.d = pick(1'b1);
      qb.push_back(e); void'(qb.pop_front());
      if (in_valid) begin
        m_last  = sel;
        m_first = 1'b0;
        if (m_cnt[sel] < 65535) m_cnt[sel]++;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("a_valid", {63'd0, ov_a}, {63'd0, qa[0].v});
      chk("a_chg",   {63'd0, ch_a}, {63'd0, qa[0].c});
      if (qa[0].known) chk("a_out", {16'd0, out_a}, {16'd0, qa[0].d});
      chk("b_valid", {63'd0, ov_b}, {63'd0, qb[0].v});
      chk("b_chg",   {63'd0, ch_b}, {63'd0, qb[0].c});
      if (qb[0].known) chk("b_out", {16'd0, out_b}, {16'd0, qb[0].d});
`ifdef DSP_OPMUX_USAGE_CNT_EN
      chk("a_cnt", cnt_a, {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
      chk("b_cnt", cnt_b, {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit c, input bit v, input logic [1:0] s);
    rst_n = r; ce = c; in_valid = v; sel = s;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b1; sel = 2'd0;
    in0 = 48'h1; in1 = 36'h8_0000_0001; in2 = 48'h3; in3 = 48'h4;
    @(posedge clk);
    #2;

    // Reset held with valid traffic: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 2'(i));
      chk("rst_out_b", {16'd0, out_b}, 64'd0);
      chk("rst_ov_a",  {63'd0, ov_a}, 64'd0);
      chk("rst_ov_b",  {63'd0, ov_b}, 64'd0);
      chk("rst_chg_a", {63'd0, ch_a}, 64'd0);
    end

    // Select sweep straight out of reset.
    cyc(1'b1, 1'b1, 1'b1, 2'd0);
    chk("lat_ov_a", {63'd0, ov_a}, 64'd0);
    cyc(1'b1, 1'b1, 1'b1, 2'd1);
    chk("sw0_a",   {16'd0, out_a}, 64'h1);
    chk("sw0_ch",  {63'd0, ch_a}, 64'd0);
    chk("sw0_ovb", {63'd0, ov_b}, 64'd0);
    cyc(1'b1, 1'b1, 1'b1, 2'd2);
    chk("sw1_a",   {16'd0, out_a}, 64'h0008_0000_0001);
    chk("sw1_ch",  {63'd0, ch_a}, 64'd1);
    chk("sw0_b",   {16'd0, out_b}, 64'h1);
    cyc(1'b1, 1'b1, 1'b1, 2'd3);
    chk("sw2_a",   {16'd0, out_a}, 64'h3);
    chk("sext_b",  {16'd0, out_b}, 64'hFFF8_0000_0001);
    chk("sw1_chb", {63'd0, ch_b}, 64'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("sw3_a",   {16'd0, out_a}, 64'h4);
    chk("sw3_ch",  {63'd0, ch_a}, 64'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("sw_end_ova", {63'd0, ov_a}, 64'd0);
    chk("sw3_b",   {16'd0, out_b}, 64'h4);

    // Positive narrow operand under sign extension.
    in1 = 36'h7_FFFF_FFFF;
    cyc(1'b1, 1'b1, 1'b1, 2'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd1);
    chk("pos_a", {16'd0, out_a}, 64'h0007_FFFF_FFFF);
    cyc(1'b1, 1'b1, 1'b0, 2'd1);
    chk("pos_b", {16'd0, out_b}, 64'h0007_FFFF_FFFF);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 2'd0);

    // Clock enable gap with a sample mid-pipe.
    in2 = 48'h1234_5678_9ABC;
    cyc(1'b1, 1'b1, 1'b1, 2'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 2'd3);
      chk("ce_hold_ova", {63'd0, ov_a}, 64'd0);
      chk("ce_hold_ovb", {63'd0, ov_b}, 64'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("ce_a_ov",  {63'd0, ov_a}, 64'd1);
    chk("ce_a_out", {16'd0, out_a}, 64'h1234_5678_9ABC);
    chk("ce_b_ov0", {63'd0, ov_b}, 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("ce_b_ov",  {63'd0, ov_b}, 64'd1);
    chk("ce_b_out", {16'd0, out_b}, 64'h1234_5678_9ABC);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("ce_b_nodup", {63'd0, ov_b}, 64'd0);

    // Change detect across invalid gaps.
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b1, 2'd2);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("gap1_ov", {63'd0, ov_a}, 64'd1);
    chk("gap1_ch", {63'd0, ch_a}, 64'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b1, 2'd2);
    cyc(1'b1, 1'b1, 1'b1, 2'd3);
    chk("gap2_ov", {63'd0, ov_a}, 64'd1);
    chk("gap2_ch", {63'd0, ch_a}, 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("gap3_ch", {63'd0, ch_a}, 64'd1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 2'd0);

    // Randomised traffic with occasional resets and ce drops.
    for (int i = 0; i < 3000; i++) begin
      in0 = 48'({$urandom, $urandom});
      in2 = 48'({$urandom, $urandom});
      in3 = 48'({$urandom, $urandom});
      case ($urandom_range(0, 3))
        0:       in1 = 36'h8_0000_0000;
        1:       in1 = 36'h7_FFFF_FFFF;
        default: in1 = 36'({$urandom, $urandom});
      endcase
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8,
          $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)));
    end

`ifdef DSP_OPMUX_USAGE_CNT_EN
    // Counter saturation and clear.
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (70000) cyc(1'b1, 1'b1, 1'b1, 2'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chk("cnt_sat", {48'd0, cnt_a[31:16]}, 64'hFFFF);
    chk("cnt_s0",  {48'd0, cnt_a[15:0]}, 64'd3);
    cyc(1'b0, 1'b1, 1'b1, 2'd1);
    chk("cnt_clr", cnt_b, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
